// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Writer side of the byte-addressed instruction memory. Accepts
//            32-bit words on a valid/ready stream and writes each as four
//            big-endian bytes (MSB at the lowest address). hold_pipeline
//            stalls fetch while a load is in progress.
// Options  : LOADER_CHECKSUM_EN - when defined, checksum carries the 32-bit
//            wrapping sum of the words accepted in the current load;
//            otherwise checksum is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              hold_pipeline,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words_loaded,
  output logic [31:0]       checksum
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_WR0    = 3'd2;
  localparam logic [2:0] S_WR1    = 3'd3;
  localparam logic [2:0] S_WR2    = 3'd4;
  localparam logic [2:0] S_WR3    = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  // Memory holds 2^ADDR_W bytes, i.e. 2^(ADDR_W-2) words at most per load.
  localparam int MAX_WORDS = 1 << (ADDR_W - 2);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  remaining;
  logic [31:0]       word_reg;
  logic              busy_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  loaded_reg;

  logic request_legal;
  logic start_ok;
  logic handshake;

  assign request_legal = (int'(word_count) <= MAX_WORDS) && (base_addr[1:0] == 2'b00);
  assign start_ok      = (state == S_IDLE) && start && request_legal;
  assign in_ready      = (state == S_WAIT);
  assign handshake     = in_valid && in_ready;
  assign done          = (state == S_FINISH);
  assign busy          = busy_reg;
  assign hold_pipeline = busy_reg;
  assign err           = err_reg;
  assign words_loaded  = loaded_reg;

  // Byte-write port: address/data forced to zero whenever no write is issued.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (state)
      S_WR0: begin
        mem_we    = 1'b1;
        mem_addr  = addr_reg;
        mem_wdata = word_reg[31:24];
      end
      S_WR1: begin
        mem_we    = 1'b1;
        mem_addr  = addr_reg + ADDR_W'(1);
        mem_wdata = word_reg[23:16];
      end
      S_WR2: begin
        mem_we    = 1'b1;
        mem_addr  = addr_reg + ADDR_W'(2);
        mem_wdata = word_reg[15:8];
      end
      S_WR3: begin
        mem_we    = 1'b1;
        mem_addr  = addr_reg + ADDR_W'(3);
        mem_wdata = word_reg[7:0];
      end
      default: ;
    endcase
  end

  // Load sequencer: request check, word capture, byte serialisation, completion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      addr_reg   <= '0;
      remaining  <= '0;
      word_reg   <= 32'h0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
      loaded_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (request_legal) begin
              addr_reg   <= base_addr;
              remaining  <= word_count;
              loaded_reg <= '0;
              busy_reg   <= 1'b1;
              state      <= (word_count != '0) ? S_WAIT : S_FINISH;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (handshake) begin
            word_reg <= in_word;
            state    <= S_WR0;
          end
        end
        S_WR0: state <= S_WR1;
        S_WR1: state <= S_WR2;
        S_WR2: state <= S_WR3;
        S_WR3: begin
          // Address wraps naturally at the top of the byte space.
          addr_reg   <= addr_reg + ADDR_W'(4);
          remaining  <= remaining - CNT_W'(1);
          loaded_reg <= loaded_reg + CNT_W'(1);
          state      <= (remaining == CNT_W'(1)) ? S_FINISH : S_WAIT;
        end
        S_FINISH: begin
          busy_reg <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_reg;

  // Running sum of accepted words; held after done until the next accepted start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sum_reg <= 32'h0;
    end else if (start_ok) begin
      sum_reg <= 32'h0;
    end else if (handshake) begin
      sum_reg <= sum_reg + in_word;
    end
  end

  assign checksum = sum_reg;
`else
  assign checksum = 32'h0;
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Self-checking bench for instr_mem_loader: directed scenarios plus
//            randomized traffic compared every cycle against a word/byte-level
//            reference model. Checksum expectations follow LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [6:0]  word_count;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        hold_pipeline;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;
  logic [31:0] checksum;

  instr_mem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .hold_pipeline(hold_pipeline),
    .done(done), .err(err), .words_loaded(words_loaded), .checksum(checksum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [7:0] tb_mem [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (load / word / byte level) ----------------
  // m_phase: -1 waiting for a word, 0..3 writing byte k, 4 completion cycle.
  bit          m_busy;
  int          m_phase;
  int          m_base;
  int          m_total;
  int          m_done_words;
  logic [31:0] m_word;
  logic [31:0] m_sum;
  bit          m_err;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_busy <= 0; m_phase <= 0; m_base <= 0; m_total <= 0;
      m_done_words <= 0; m_word <= 0; m_sum <= 0; m_err <= 0;
    end else begin
      m_err <= 0;
      if (!m_busy) begin
        if (start) begin
          if (int'(word_count) <= 64 && base_addr % 4 == 0) begin
            m_busy <= 1; m_base <= int'(base_addr); m_total <= int'(word_count);
            m_done_words <= 0; m_sum <= 0;
            m_phase <= (word_count == 0) ? 4 : -1;
          end else begin
            m_err <= 1;
          end
        end
      end else if (m_phase == -1) begin
        if (in_valid) begin
          m_word <= in_word; m_sum <= m_sum + in_word; m_phase <= 0;
        end
      end else if (m_phase < 3) begin
        m_phase <= m_phase + 1;
      end else if (m_phase == 3) begin
        m_done_words <= m_done_words + 1;
        m_phase <= (m_done_words + 1 == m_total) ? 4 : -1;
      end else begin
        m_busy <= 0;
      end
    end
  end

  // ---------------- per-cycle comparison against the model -------------------
  always @(negedge Clk) begin
    logic        e_we;
    logic [7:0]  e_addr, e_data;
    logic [31:0] e_sum;
    e_we   = m_busy && m_phase >= 0 && m_phase <= 3;
    e_addr = e_we ? 8'((m_base + 4 * m_done_words + m_phase) % 256) : 8'h00;
    e_data = e_we ? 8'(m_word >> (24 - 8 * m_phase)) : 8'h00;
`ifdef LOADER_CHECKSUM_EN
    e_sum = m_sum;
`else
    e_sum = 32'h0;
`endif
    check("in_ready",      {31'b0, in_ready},      {31'b0, m_busy && m_phase == -1});
    check("mem_we",        {31'b0, mem_we},        {31'b0, e_we});
    check("mem_addr",      {24'b0, mem_addr},      {24'b0, e_addr});
    check("mem_wdata",     {24'b0, mem_wdata},     {24'b0, e_data});
    check("busy",          {31'b0, busy},          {31'b0, m_busy});
    check("hold_pipeline", {31'b0, hold_pipeline}, {31'b0, m_busy});
    check("done",          {31'b0, done},          {31'b0, m_busy && m_phase == 4});
    check("err",           {31'b0, err},           {31'b0, m_err});
    check("words_loaded",  {25'b0, words_loaded},  32'(m_done_words));
    check("checksum",      checksum,               e_sum);
    if (mem_we) begin
      tb_mem[mem_addr] = mem_wdata;
      n_writes++;
    end
  end

  // ---------------- stimulus helpers (entered/left at posedge+1) --------------
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [6:0] c);
    start = 1; base_addr = b; word_count = c;
    tick();
    start = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    bit ok;
    ok = 0;
    in_valid = 1; in_word = w;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    check("handshake_seen", {31'b0, ok}, 32'd1);
    tick();
    in_valid = 0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1; break; end
      tick();
    end
    check("done_seen", {31'b0, ok}, 32'd1);
    tick();
  endtask

  logic [7:0] exp_bytes [0:11];
  int w0;

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h5A;
    Reset_n = 0; start = 0; base_addr = 0; word_count = 0; in_valid = 0; in_word = 0;
    repeat (3) tick();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_words_loaded", {25'b0, words_loaded}, 32'd0);
    check("reset_checksum", checksum, 32'd0);
    Reset_n = 1;
    tick();

    // Single word
    do_start(8'h00, 7'd1);
    send_word(32'hE3A01005, 0);
    wait_done(20);
    check("single_b0", {24'b0, tb_mem[8'h00]}, 32'hE3);
    check("single_b1", {24'b0, tb_mem[8'h01]}, 32'hA0);
    check("single_b2", {24'b0, tb_mem[8'h02]}, 32'h10);
    check("single_b3", {24'b0, tb_mem[8'h03]}, 32'h05);
    check("single_count", {25'b0, words_loaded}, 32'd1);

    // Stream with gaps
    do_start(8'h10, 7'd3);
    send_word(32'h11223344, 2);
    send_word(32'hAABBCCDD, 2);
    send_word(32'h00000000, 0);
    wait_done(20);
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                  8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 12; i++)
      check("stream_byte", {24'b0, tb_mem[8'h10 + i]}, {24'b0, exp_bytes[i]});
    check("stream_count", {25'b0, words_loaded}, 32'd3);
`ifdef LOADER_CHECKSUM_EN
    check("stream_checksum", checksum, 32'hBBDE0021);
`else
    check("stream_checksum", checksum, 32'h0);
`endif

    // Address wrap
    do_start(8'hFC, 7'd2);
    send_word(32'h01020304, 1);
    send_word(32'h05060708, 0);
    wait_done(20);
    for (int i = 0; i < 4; i++) begin
      check("wrap_hi", {24'b0, tb_mem[8'hFC + i]}, 32'(i + 1));
      check("wrap_lo", {24'b0, tb_mem[i]}, 32'(i + 5));
    end

    // Illegal and zero-count requests
    do_start(8'h00, 7'd65);
    check("err_count", {31'b0, err}, 32'd1);
    check("err_count_busy", {31'b0, busy}, 32'd0);
    tick();
    do_start(8'h02, 7'd1);
    check("err_align", {31'b0, err}, 32'd1);
    tick();
    w0 = n_writes;
    do_start(8'h40, 7'd0);
    check("zero_done", {31'b0, done}, 32'd1);
    check("zero_busy", {31'b0, busy}, 32'd1);
    tick();
    check("zero_idle", {31'b0, busy}, 32'd0);
    check("zero_no_writes", 32'(n_writes - w0), 32'd0);

    // Reset during WR1 of word 0
    do_start(8'h80, 7'd2);
    in_valid = 1; in_word = 32'hCAFEBABE;
    tick();
    in_valid = 0;
    tick();
    #2 Reset_n = 0;
    #1;
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    @(posedge Clk); #2 Reset_n = 1;
    tick();
    do_start(8'h80, 7'd1);
    send_word(32'h12345678, 0);
    wait_done(20);
    check("after_rst_b0", {24'b0, tb_mem[8'h80]}, 32'h12);
    check("after_rst_b3", {24'b0, tb_mem[8'h83]}, 32'h78);

    // start while busy is ignored
    do_start(8'h20, 7'd2);
    do_start(8'h60, 7'd5);
    send_word(32'hDEADBEEF, 1);
    send_word(32'h0BADF00D, 0);
    wait_done(20);
    check("busy_start_count", {25'b0, words_loaded}, 32'd2);
    check("busy_start_idle", {31'b0, busy}, 32'd0);

    // Randomized traffic, model checked every cycle
    for (int cyc = 0; cyc < 4000; cyc++) begin
      start      = ($urandom_range(0, 5) == 0);
      base_addr  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (8'($urandom) & 8'hFC);
      word_count = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6));
      in_valid   = $urandom_range(0, 1) == 1;
      in_word    = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        Reset_n = 0;
        tick();
        Reset_n = 1;
      end
      tick();
    end
    start = 0; in_valid = 0; Reset_n = 1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and serialises each one into four byte writes, big-endian: MSB at the lowest address. This matches the fetch side, which assembles {mem[A], mem[A+1], mem[A+2], mem[A+3]}. While a load runs it asserts a hold signal that gates the PC and IF/ID enables, so no fetch sees a partially written word.

Parameters:
ADDR_W, 8, byte address width of instruction memory (depth 2^ADDR_W bytes)
CNT_W, 7, width of word_count; largest legal count = 2^(ADDR_W-2) = 64

Ports:
Clk  input  1  clock, rising edge
Reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle load request; sampled only in IDLE
base_addr  input  ADDR_W  first byte address; bits [1:0] must be 00
word_count  input  CNT_W  number of words to load
in_valid  input  1  in_word valid
in_word  input  32  instruction word
in_ready  output  1  loader accepts in_word this cycle
mem_we  output  1  byte write strobe
mem_addr  output  ADDR_W  byte write address
mem_wdata  output  8  byte write data
busy  output  1  high from start acceptance until done
hold_pipeline  output  1  equals busy; drives PC/IF_ID enable low
done  output  1  one-cycle pulse at end of load
err  output  1  one-cycle pulse on rejected start
words_loaded  output  CNT_W  words fully written in current/last load
checksum  output  32  see Optional Feature

Behaviour:
- Reset (Reset_n low, asynchronous): state IDLE. All outputs are 0, including words_loaded and checksum. Bytes already written stay in memory.
- FSM states: IDLE, WAIT_WORD, WR0, WR1, WR2, WR3, FINISH.
- IDLE + start, legal request:
  - Legal means word_count <= 64 and base_addr[1:0] == 00.
  - Latch base_addr into addr_reg and word_count into remaining.
  - Clear words_loaded.
  - Next state is WAIT_WORD if word_count != 0, else FINISH.
- IDLE + start, illegal request: err = 1 for one cycle; stay in IDLE; busy stays 0.
- start is ignored in every state except IDLE.
- WAIT_WORD:
  - in_ready = 1.
  - A handshake occurs when in_valid && in_ready; it latches in_word into word_reg and moves to WR0.
  - in_ready = 0 in all other states. There is no back-to-back acceptance, so per-word throughput is 5 cycles minimum.
- WRk, k = 0..3:
  - mem_we = 1, mem_addr = addr_reg + k, mem_wdata = word_reg[31-8k -: 8].
  - First byte write occurs the cycle after the handshake.
- Leaving WR3:
  - addr_reg += 4, wrapping modulo 2^ADDR_W (0xFC -> 0x00).
  - remaining -= 1; words_loaded += 1.
  - If remaining becomes 0, go to FINISH, else go to WAIT_WORD.
- FINISH: done = 1 for exactly one cycle, then IDLE.
- busy:
  - Registered; 1 in every state except IDLE.
  - Rises the cycle after start is accepted; falls the cycle after FINISH.
- mem_addr and mem_wdata are 0 whenever mem_we = 0.
- Zero-count load: start -> busy=1 (FINISH, done=1) -> IDLE. No mem_we at all.
- Reset asserted mid-load aborts the load immediately. No done pulse is produced. A word already accepted may be partially written.
- in_valid held high outside WAIT_WORD has no effect, and the word is not consumed.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - checksum is a 32-bit wrapping sum of all words accepted in the current load.
  - It is cleared when start is accepted and updated on each handshake.
  - It is held stable after done until the next accepted start.
- Undefined: checksum is tied to 32'h0 and no adder is synthesised.

Test Plan:
- Single word: base_addr=0x00, count=1, word 0xE3A01005 -> bytes E3,A0,10,05 written at 0x00..0x03 on 4 consecutive cycles; done pulse 1 cycle after the WR3 cycle; words_loaded=1.
- Stream with gaps: count=3, words 0x11223344, 0xAABBCCDD, 0x00000000 with in_valid low 2 cycles between each -> 12 byte writes at 0x10..0x1B in order; in_ready high only in WAIT_WORD; hold_pipeline high throughout; with LOADER_CHECKSUM_EN, checksum=0xBBDE0021.
- Wrap: base_addr=0xFC, count=2, words 0x01020304, 0x05060708 -> bytes 01..04 at 0xFC..0xFF, bytes 05..08 at 0x00..0x03.
- Illegal requests: start with count=65 -> err pulse, busy stays 0. start with base_addr=0x02 -> err pulse. start with count=0 -> done pulse, zero mem_we.
- Reset mid-op: count=2, deassert Reset_n during WR1 of word 0 -> all outputs 0 immediately; after release, state IDLE and start accepted normally.
- start while busy: second start with count=5 during WAIT_WORD -> ignored; original load of 2 words completes with words_loaded=2.
